// File: rtl/dl_write_buffer.sv
// dl_write_buffer: queues HPS ioctl download words and replays them one
// at a time to the SDRAM mux, paced by the controller's idle/busy line.
// Ports:
//   CLK, RESET      clock, async active-high reset
//   IOCTL_DOWNLOAD  HPS download in progress
//   IOCTL_WR/ADDR/DOUT  write strobe, byte address, word from hps_io
//   IOCTL_WAIT      throttles the HPS when the queue is nearly full
//   DL_EN/WR/ADDR/DATA  download port of the SDRAM mux
//   SDRAM_READY     controller idle (1) / busy (0)
//   OVERFLOW        sticky: write dropped on a full queue
//   TIMEOUT_ERR     sticky: controller never went busy after a write
`timescale 1ns/1ps
module dl_write_buffer #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [26:0] ADDR_OFFSET = 27'h0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IOCTL_DOWNLOAD,
  input  logic        IOCTL_WR,
  input  logic [26:0] IOCTL_ADDR,
  input  logic [15:0] IOCTL_DOUT,
  output logic        IOCTL_WAIT,
  output logic        DL_EN,
  output logic        DL_WR,
  output logic [26:0] DL_ADDR,
  output logic [15:0] DL_DATA,
  input  logic        SDRAM_READY,
  output logic        OVERFLOW,
  output logic        TIMEOUT_ERR
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] HWM    = CW'(DEPTH - 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);
  localparam logic [26:0]   EVEN   = 27'h7FFFFFE;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  typedef struct packed {
    logic [26:0] addr;
    logic [15:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  state_t        state;
  state_t        state_nx;
  logic [WW-1:0] wdog;
  logic          push;
  logic          pop;
  logic          wd_run;
  logic          wd_fire;
  logic          dl_q;
  logic          dl_rise;
  logic          drop;
  logic [26:0]   head_addr;

  logic          wait_r;
  logic          en_r;
  logic [26:0]   addr_r;
  logic [15:0]   data_r;
  logic          ovf_r;
  logic          tmo_r;

  assign push    = IOCTL_WR && (count < FULL);
  assign drop    = IOCTL_WR && (count == FULL);
  assign dl_rise = IOCTL_DOWNLOAD && !dl_q;
  assign head    = mem[rd_ptr];

  // Bit 0 is dropped before and after the offset so the
  // issued address is always word aligned; carry out wraps.
  assign head_addr = ((head.addr & EVEN) + ADDR_OFFSET) & EVEN;

  always_comb begin
    count_nx = count;
    unique case ({push, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    wd_run   = 1'b0;
    wd_fire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0 && SDRAM_READY) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!SDRAM_READY) begin
          state_nx = WAIT_DONE;
        end else if (wdog == WD_MAX) begin
          // Controller never acknowledged: abandon the word.
          wd_fire  = 1'b1;
          state_nx = IDLE;
        end else begin
          wd_run = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (SDRAM_READY) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: IOCTL_ADDR, data: IOCTL_DOUT};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      wdog   <= '0;
      dl_q   <= 1'b0;
      wait_r <= 1'b0;
      en_r   <= 1'b0;
      addr_r <= '0;
      data_r <= '0;
      ovf_r  <= 1'b0;
      tmo_r  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      dl_q  <= IOCTL_DOWNLOAD;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        addr_r <= head_addr;
        data_r <= head.data;
      end
      wdog   <= wd_run ? wdog + WW'(1) : '0;
      wait_r <= (count_nx >= HWM);
      // Stay enabled while anything is queued or in flight so
      // the tail of a download drains after IOCTL_DOWNLOAD falls.
      en_r <= IOCTL_DOWNLOAD
            | (count_nx != '0)
            | (state_nx != IDLE);
      if (dl_rise) begin
        ovf_r <= 1'b0;
        tmo_r <= 1'b0;
      end
      if (drop) begin
        ovf_r <= 1'b1;
      end
      if (wd_fire) begin
        tmo_r <= 1'b1;
      end
    end
  end

  assign IOCTL_WAIT  = wait_r;
  assign DL_EN       = en_r;
  assign DL_WR       = (state == ISSUE);
  assign DL_ADDR     = addr_r;
  assign DL_DATA     = data_r;
  assign OVERFLOW    = ovf_r;
  assign TIMEOUT_ERR = tmo_r;

endmodule
